// File: rtl/alu_pipe_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pipe_responder                                           |
// | Description : ALU request responder. Valid/ready request intake, 2-stage   |
// |               compute pipeline, first-word-fall-through result FIFO with   |
// |               credit-based admission so results are never dropped.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_pipe_responder #(
   parameter int DATA_W    = 32,
   parameter int OUT_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clock,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [DATA_W-1:0] dataA_i,
   input  logic [DATA_W-1:0] dataB_i,
   input  logic [2:0]        ALUCtrl_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] ALUResult_o,
   output logic              Zero_o,
   output logic              Overflow_o,
   output logic [CNT_W-1:0]  rsp_count_o
);

   localparam int c_ADDR_W = $clog2(OUT_DEPTH);
   localparam int c_CNT_FW = c_ADDR_W + 1;   // FIFO occupancy 0..OUT_DEPTH
   localparam int c_PEND_W = c_ADDR_W + 2;   // occupancy + in-flight + headroom
   localparam int c_MSB    = DATA_W - 1;

   localparam logic [2:0] c_OP_AND = 3'b000;
   localparam logic [2:0] c_OP_OR  = 3'b001;
   localparam logic [2:0] c_OP_ADD = 3'b010;
   localparam logic [2:0] c_OP_XOR = 3'b011;
   localparam logic [2:0] c_OP_NOR = 3'b100;
   localparam logic [2:0] c_OP_SRL = 3'b101;
   localparam logic [2:0] c_OP_SUB = 3'b110;
   localparam logic [2:0] c_OP_SLT = 3'b111;

   // Stage 1: captured request
   logic              r_s1_v;
   logic [DATA_W-1:0] r_s1_a;
   logic [DATA_W-1:0] r_s1_b;
   logic [2:0]        r_s1_op;

   // Stage 2: computed result and flags
   logic              r_s2_v;
   logic [DATA_W-1:0] r_s2_res;
   logic              r_s2_zero;
   logic              r_s2_ovf;

   // Output FIFO; entry layout is {overflow, zero, result}
   logic [DATA_W+1:0]   r_mem [OUT_DEPTH];
   logic [c_ADDR_W-1:0] r_wr_ptr;
   logic [c_ADDR_W-1:0] r_rd_ptr;
   logic [c_CNT_FW-1:0] r_count;
   logic [CNT_W-1:0]    r_rsp_count;

   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic [c_PEND_W-1:0] w_pending;
   logic [DATA_W-1:0] w_alu_res;
   logic              w_alu_ovf;
   logic [DATA_W+1:0] w_head;

   assign w_push   = r_s2_v;
   assign w_pop    = rsp_valid_o && rsp_ready_i;
   assign w_full   = (r_count == c_CNT_FW'(OUT_DEPTH));
   assign w_accept = req_valid_i && req_ready_o;

   // Every result already committed to (queued or in the pipe) holds a FIFO slot;
   // a pop this cycle returns its slot immediately so a full FIFO can still accept.
   assign w_pending   = c_PEND_W'(r_count) + c_PEND_W'(r_s1_v) + c_PEND_W'(r_s2_v);
   assign req_ready_o = !rst_i &&
                        (w_pending < (c_PEND_W'(OUT_DEPTH) + c_PEND_W'(w_pop)));

   // ALU datapath operating on stage-1 operands
   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      case (r_s1_op)
         c_OP_AND: w_alu_res = r_s1_a & r_s1_b;
         c_OP_OR:  w_alu_res = r_s1_a | r_s1_b;
         c_OP_ADD: begin
            w_alu_res = r_s1_a + r_s1_b;
            w_alu_ovf = (r_s1_a[c_MSB] == r_s1_b[c_MSB]) &&
                        (w_alu_res[c_MSB] != r_s1_a[c_MSB]);
         end
         c_OP_XOR: w_alu_res = r_s1_a ^ r_s1_b;
         c_OP_NOR: w_alu_res = ~(r_s1_a | r_s1_b);
         c_OP_SRL: w_alu_res = r_s1_a >> r_s1_b[4:0];
         c_OP_SUB: begin
            // Subtraction overflows when operand signs differ and the result
            // sign departs from A (equivalent to adding -B).
            w_alu_res = r_s1_a - r_s1_b;
            w_alu_ovf = (r_s1_a[c_MSB] != r_s1_b[c_MSB]) &&
                        (w_alu_res[c_MSB] != r_s1_a[c_MSB]);
         end
         c_OP_SLT: w_alu_res = {{(DATA_W-1){1'b0}},
                                ($signed(r_s1_a) < $signed(r_s1_b))};
         default:  w_alu_res = '0;
      endcase
   end

   // Two-stage pipeline; it never stalls because admission reserved a FIFO slot
   always_ff @(posedge clock or posedge rst_i) begin
      if (rst_i) begin
         r_s1_v    <= 1'b0;
         r_s1_a    <= '0;
         r_s1_b    <= '0;
         r_s1_op   <= '0;
         r_s2_v    <= 1'b0;
         r_s2_res  <= '0;
         r_s2_zero <= 1'b0;
         r_s2_ovf  <= 1'b0;
      end else begin
         r_s1_v <= w_accept;
         if (w_accept) begin
            r_s1_a  <= dataA_i;
            r_s1_b  <= dataB_i;
            r_s1_op <= ALUCtrl_i;
         end
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_res  <= w_alu_res;
            r_s2_zero <= (w_alu_res == '0);
            r_s2_ovf  <= w_alu_ovf;
         end
      end
   end

   // FIFO storage; contents need no reset since outputs are masked when empty
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {r_s2_ovf, r_s2_zero, r_s2_res};
      end
   end

   // FIFO pointers, occupancy and delivered-response counter
   always_ff @(posedge clock or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rsp_count <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + c_ADDR_W'(1);
            r_rsp_count <= r_rsp_count + CNT_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_FW'(1);
            2'b01:   r_count <= r_count - c_CNT_FW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head      = r_mem[r_rd_ptr];
   assign rsp_valid_o = (r_count != '0);
   assign ALUResult_o = rsp_valid_o ? w_head[DATA_W-1:0] : '0;
   assign Zero_o      = rsp_valid_o && w_head[DATA_W];
   assign Overflow_o  = rsp_valid_o && w_head[DATA_W+1];
   assign rsp_count_o = r_rsp_count;

   // Credit accounting must make a push into a full FIFO impossible
   a_no_fifo_overflow : assert property (
      @(posedge clock) disable iff (rst_i) !(w_push && w_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_pipe_responder                                        |
// | Description : Scoreboard bench for alu_pipe_responder with directed        |
// |               vectors and hand-computed expected results.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_pipe_responder;

   logic        clock = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] dataA_i = '0;
   logic [31:0] dataB_i = '0;
   logic [2:0]  ALUCtrl_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] ALUResult_o;
   logic        Zero_o;
   logic        Overflow_o;
   logic [15:0] rsp_count_o;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        o;
      int          acc_cyc;
      bit          chk_lat;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   n_acc = 0;
   int   pops  = 0;

   // Stream table for the back-pressure test
   logic [2:0]  tab_op [8] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd2, 3'd6, 3'd7, 3'd2};
   logic [31:0] tab_a  [8] = '{32'hF0F0F0F0, 32'hF0000000, 32'hAAAAAAAA, 32'h00000000,
                               32'h80000000, 32'h80000000, 32'h00000001, 32'h00000003};
   logic [31:0] tab_b  [8] = '{32'h0FF00FF0, 32'h0000000F, 32'hFFFFFFFF, 32'h00000000,
                               32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000004};
   logic [31:0] tab_r  [8] = '{32'h00F000F0, 32'hF000000F, 32'h55555555, 32'hFFFFFFFF,
                               32'h00000000, 32'h7FFFFFFF, 32'h00000000, 32'h00000007};
   logic        tab_z  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic        tab_o  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   alu_pipe_responder #(.DATA_W(32), .OUT_DEPTH(4), .CNT_W(16)) dut (
      .clock       (clock),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .dataA_i     (dataA_i),
      .dataB_i     (dataB_i),
      .ALUCtrl_i   (ALUCtrl_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .ALUResult_o (ALUResult_o),
      .Zero_o      (Zero_o),
      .Overflow_o  (Overflow_o),
      .rsp_count_o (rsp_count_o)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Present one request, wait (bounded) for acceptance, then log its expectation
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic eo, input bit lat);
      bit   ok;
      exp_t e;
      ok          = 1'b0;
      ALUCtrl_i   = op;
      dataA_i     = a;
      dataB_i     = b;
      req_valid_i = 1'b1;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clock);
         ok = req_ready_o;
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got ready=0 expected ready=1 (op %0d)", op);
         req_valid_i = 1'b0;
         return;
      end
      @(posedge clock);
      #1;
      e.res = er; e.z = ez; e.o = eo; e.acc_cyc = cyc; e.chk_lat = lat;
      sb_q.push_back(e);
      n_acc++;
      req_valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clock);
      check("drain_empty", 64'(sb_q.size()), 64'd0);
      repeat (3) @(negedge clock);
   endtask

   task automatic stream8();
      for (int i = 0; i < 8; i++) send(tab_op[i], tab_a[i], tab_b[i], tab_r[i], tab_z[i], tab_o[i], 1'b0);
   endtask

   // Monitor: compare every popped head against the scoreboard
   always @(negedge clock) begin
      if (!rst_i) begin
         if (rsp_valid_o) begin
            if (rsp_ready_i) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_rsp", 64'(ALUResult_o), 64'hDEAD);
               end else begin
                  mon_e = sb_q.pop_front();
                  check("result",   64'(ALUResult_o), 64'(mon_e.res));
                  check("zero",     64'(Zero_o),      64'(mon_e.z));
                  check("overflow", 64'(Overflow_o),  64'(mon_e.o));
                  if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.acc_cyc), 64'd2);
               end
               check("rsp_count", 64'(rsp_count_o), 64'(pops[15:0]));
               pops++;
            end
         end else begin
            check("empty_outputs", 64'({ALUResult_o, Zero_o, Overflow_o}), 64'd0);
         end
      end
   end

   initial begin
      int base;
      // Reset state
      repeat (2) @(negedge clock);
      check("reset_outputs", 64'({rsp_valid_o, ALUResult_o, Zero_o, Overflow_o}), 64'd0);
      check("reset_ready", 64'(req_ready_o), 64'd0);
      check("reset_count", 64'(rsp_count_o), 64'd0);
      rst_i = 1'b0;
      @(negedge clock);
      check("idle_ready", 64'(req_ready_o), 64'd1);

      // 1: signed overflow on ADD, latency 2
      rsp_ready_i = 1'b1;
      @(posedge clock); #1;
      send(3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1);
      drain();

      // 2: back-to-back SUB then SLT
      @(posedge clock); #1;
      send(3'd6, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1);
      send(3'd7, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
      drain();

      // 3: consumer stalled, stream of 8 requests
      @(posedge clock); #1;
      rsp_ready_i = 1'b0;
      base = n_acc;
      fork
         stream8();
      join_none
      repeat (12) @(negedge clock);
      check("t3_accepted", 64'(n_acc - base), 64'd4);
      check("t3_ready_low", 64'(req_ready_o), 64'd0);
      check("t3_valid", 64'(rsp_valid_o), 64'd1);

      // 4: full FIFO, pop and accept in the same cycle
      @(posedge clock); #1;
      rsp_ready_i = 1'b1;
      @(negedge clock);
      check("t4_ready_on_pop", 64'(req_ready_o), 64'd1);
      @(posedge clock); #1;
      rsp_ready_i = 1'b0;
      @(negedge clock);
      check("t4_credit_held", 64'(req_ready_o), 64'd0);
      check("t4_accepted", 64'(n_acc - base), 64'd5);
      @(posedge clock); #1;
      rsp_ready_i = 1'b1;
      for (int k = 0; k < 200 && (n_acc - base) < 8; k++) @(negedge clock);
      check("t3_all_accepted", 64'(n_acc - base), 64'd8);
      drain();

      // 5: reset with three requests in flight
      @(posedge clock); #1;
      rsp_ready_i = 1'b0;
      send(3'd1, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0, 1'b0);
      send(3'd1, 32'h44, 32'h00, 32'h44, 1'b0, 1'b0, 1'b0);
      send(3'd1, 32'h55, 32'h00, 32'h55, 1'b0, 1'b0, 1'b0);
      check("t5_pre_valid", 64'(rsp_valid_o), 64'd1);
      rst_i = 1'b1;
      #1;
      check("t5_rst_outputs", 64'({rsp_valid_o, ALUResult_o, Zero_o, Overflow_o}), 64'd0);
      check("t5_rst_ready", 64'(req_ready_o), 64'd0);
      check("t5_rst_count", 64'(rsp_count_o), 64'd0);
      sb_q.delete();
      pops = 0;
      repeat (2) @(negedge clock);
      rst_i = 1'b0;
      repeat (4) @(negedge clock);
      check("t5_no_stale", 64'(rsp_valid_o), 64'd0);

      // 6: SRL uses B[4:0]; then wrap the response counter
      @(posedge clock); #1;
      rsp_ready_i = 1'b1;
      send(3'd5, 32'h80000000, 32'h00000021, 32'h40000000, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 65536; i++) send(3'd1, 32'(i), 32'd0, 32'(i), 1'b0, 1'b0, 1'b0);
      drain();
      check("t6_pops", 64'(pops), 64'd65536);
      check("t6_wrap", 64'(rsp_count_o), 64'd0);

      check("leftover", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
